multicycle_control_fsm: RTL

//  Main sequencer of the multicycle control unit; the producer side of the conditional-logic interface.

---
 rtl/multicycle_control_fsm.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multicycle control sequencer: steps each instruction through fetch/decode/execute/writeback
// and raises the unconditional write requests that the conditional logic then gates.
module multicycle_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         Op,
    input  logic [5:0]         Funct,
    input  logic               RdIsPC,
    input  logic               MemReady,
    output logic               PCS,
    output logic               RegW,
    output logic               MemW,
    output logic [1:0]         FlagW,
    output logic               IRWrite,
    output logic               NextPC,
    output logic               AdrSrc,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUControl,
    output logic               Halted,
    output logic [STATE_W-1:0] StateDbg
);

    typedef enum logic [STATE_W-1:0] {
        FETCH  = STATE_W'(0),
        DECODE = STATE_W'(1),
        MEMADR = STATE_W'(2),
        MEMRD  = STATE_W'(3),
        MEMWB  = STATE_W'(4),
        MEMWR  = STATE_W'(5),
        EXECR  = STATE_W'(6),
        EXECI  = STATE_W'(7),
        ALUWB  = STATE_W'(8),
        BRANCH = STATE_W'(9),
        HALT   = STATE_W'(10)
    } state_t;

    state_t state, state_nxt;

    logic [3:0] cmd;
    logic       is_add, is_sub, is_cmp, is_and, is_orr;
    logic [1:0] alu_op;

    assign cmd    = Funct[4:1];
    assign is_add = (cmd == 4'b0100);
    assign is_sub = (cmd == 4'b0010);
    assign is_cmp = (cmd == 4'b1010);
    assign is_and = (cmd == 4'b0000);
    assign is_orr = (cmd == 4'b1100);

    always_comb begin
        alu_op = 2'b00;
        if (is_sub || is_cmp) alu_op = 2'b01;
        else if (is_and)      alu_op = 2'b10;
        else if (is_orr)      alu_op = 2'b11;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= FETCH;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FETCH:  if (MemReady) state_nxt = DECODE;
            DECODE: begin
                case (Op)
                    2'b00:   state_nxt = Funct[5] ? EXECI : EXECR;
                    2'b01:   state_nxt = MEMADR;
                    2'b10:   state_nxt = BRANCH;
                    default: state_nxt = HALT;
                endcase
            end
            MEMADR: state_nxt = Funct[0] ? MEMRD : MEMWR;
            MEMRD:  if (MemReady) state_nxt = MEMWB;
            MEMWR:  if (MemReady) state_nxt = FETCH;
            EXECR,
            EXECI:  state_nxt = ALUWB;
            MEMWB,
            ALUWB,
            BRANCH: state_nxt = FETCH;
            HALT:   state_nxt = HALT;
            default: state_nxt = FETCH;
        endcase
    end

    always_comb begin
        PCS        = 1'b0;
        RegW       = 1'b0;
        MemW       = 1'b0;
        FlagW      = 2'b00;
        IRWrite    = 1'b0;
        NextPC     = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 2'b00;
        Halted     = 1'b0;
        case (state)
            FETCH: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                IRWrite   = MemReady;
                NextPC    = MemReady;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
            end
            MEMADR: ALUSrcB = 2'b01;
            MEMRD:  AdrSrc = 1'b1;
            MEMWR: begin
                // held through the wait so memory sees it on the MemReady cycle
                AdrSrc = 1'b1;
                MemW   = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                PCS       = RdIsPC;
                RegW      = !RdIsPC;
            end
            EXECR,
            EXECI: begin
                ALUSrcB    = (state == EXECI) ? 2'b01 : 2'b00;
                ALUControl = alu_op;
                // cmp exists only to set flags, so both groups are written regardless of S
                FlagW[1]   = Funct[0] | is_cmp;
                FlagW[0]   = (Funct[0] & (is_add | is_sub)) | is_cmp;
            end
            ALUWB: begin
                PCS  = RdIsPC & !is_cmp;
                RegW = !RdIsPC & !is_cmp;
            end
            BRANCH: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCS       = 1'b1;
            end
            HALT:    Halted = 1'b1;
            default: ;
        endcase
        // reset silences every output combinationally, even mid-cycle
        if (!rst) begin
            PCS        = 1'b0;
            RegW       = 1'b0;
            MemW       = 1'b0;
            FlagW      = 2'b00;
            IRWrite    = 1'b0;
            NextPC     = 1'b0;
            AdrSrc     = 1'b0;
            ResultSrc  = 2'b00;
            ALUSrcA    = 2'b00;
            ALUSrcB    = 2'b00;
            ALUControl = 2'b00;
            Halted     = 1'b0;
        end
    end

    assign StateDbg = state;

endmodule
